// File: rtl/calc_program_loader_pkg.sv
// calc_program_loader_pkg: shared calculator word format, depth, opcodes and loader state encoding
package calc_program_loader_pkg;

    localparam int OP_W       = 2;
    localparam int OPND_W     = 8;
    localparam int DIN_W      = OP_W + 2 * OPND_W;
    localparam int CALC_DEPTH = 16;

    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_AND = 2'd2;
    localparam logic [OP_W-1:0] OP_OR  = 2'd3;

    typedef enum logic [1:0] {FILL, PRIME, STREAM, RUN} state_t;

    function automatic logic [DIN_W-1:0] pack_word(
        input logic [OP_W-1:0]   op,
        input logic [OPND_W-1:0] a,
        input logic [OPND_W-1:0] b
    );
        return {op, a, b};
    endfunction

endpackage

// File: rtl/calc_program_loader.sv
// calc_program_loader: buffers a DEPTH-word program from the host, then resets the calculator and streams it onto DIN
//   clk, reset          : single clock, synchronous active-high reset
//   in_valid/in_ready   : host word handshake; word = {in_op, in_a, in_b}
//   calc_reset/calc_din : drive the calculator's reset and instruction input
//   busy, done          : busy in PRIME/STREAM/RUN; done pulses on the last RUN cycle
//   fill_count          : words currently buffered (0..DEPTH)
//   repeat_prog         : only with LOADER_REPEAT_EN; re-streams the buffer instead of refilling
module calc_program_loader
    import calc_program_loader_pkg::*;
#(
    parameter int DEPTH      = CALC_DEPTH,
    parameter int RUN_CYCLES = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [OPND_W-1:0] in_a,
    input  logic [OPND_W-1:0] in_b,
    output logic              calc_reset,
    output logic [DIN_W-1:0]  calc_din,
    output logic              busy,
    output logic              done,
    output logic [4:0]        fill_count
`ifdef LOADER_REPEAT_EN
    ,
    input  logic              repeat_prog
`endif
);
    localparam int KW = $clog2(DEPTH);
    localparam int RW = $clog2(RUN_CYCLES);

    state_t           state, state_nx;
    logic [KW-1:0]    k;
    logic [RW-1:0]    rc;
    logic [DIN_W-1:0] buffer [DEPTH];
    logic             full, accept, last_run, rep;

`ifdef LOADER_REPEAT_EN
    assign rep = repeat_prog;
`else
    assign rep = 1'b0;
`endif

    assign full     = fill_count == 5'(DEPTH);
    assign accept   = state == FILL && in_valid && !full;
    assign last_run = rc == RW'(RUN_CYCLES - 1);

    // Outputs decode directly from state flops, so they change only at clock edges.
    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        calc_reset = 1'b0;
        calc_din   = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            FILL: begin
                state_nx   = full ? PRIME : FILL;
                in_ready   = !full;
                calc_reset = 1'b1;
                busy       = 1'b0;
            end
            PRIME: begin
                state_nx   = STREAM;
                calc_reset = 1'b1;
                calc_din   = buffer[0];
            end
            STREAM: begin
                state_nx = (k == KW'(DEPTH - 1)) ? RUN : STREAM;
                calc_din = buffer[k];
            end
            RUN: begin
                state_nx = last_run ? (rep ? PRIME : FILL) : RUN;
                done     = last_run;
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FILL;
            fill_count <= '0;
            k          <= '0;
            rc         <= '0;
        end else begin
            state <= state_nx;
            k     <= (state == STREAM) ? k + 1'b1 : '0;
            rc    <= (state == RUN) ? rc + 1'b1 : '0;
            if (accept)
                fill_count <= fill_count + 5'd1;
            else if (state == RUN && last_run && !rep)
                fill_count <= '0;
        end
    end

    // Program storage is intentionally not reset; fill_count alone marks validity.
    always_ff @(posedge clk) begin
        if (accept)
            buffer[fill_count[KW-1:0]] <= pack_word(in_op, in_a, in_b);
    end

endmodule

// File: tb/tb_calc_program_loader.sv
// tb_calc_program_loader: directed/random self-checking bench for calc_program_loader
module tb_calc_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [1:0]  in_op = '0;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_ready, calc_reset, busy, done;
    logic [17:0] calc_din;
    logic [4:0]  fill_count;
`ifdef LOADER_REPEAT_EN
    logic        repeat_prog = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [17:0] mdl[$];

    always #5 clk = ~clk;

    calc_program_loader dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_a(in_a),
        .in_b(in_b),
        .calc_reset(calc_reset),
        .calc_din(calc_din),
        .busy(busy),
        .done(done),
`ifdef LOADER_REPEAT_EN
        .repeat_prog(repeat_prog),
`endif
        .fill_count(fill_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic rdy, input logic cr,
                              input logic [17:0] din, input logic bsy, input logic dn,
                              input logic [4:0] fc);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".calc_reset"}, 32'(calc_reset), 32'(cr));
        chk({tag, ".calc_din"}, 32'(calc_din), 32'(din));
        chk({tag, ".busy"}, 32'(busy), 32'(bsy));
        chk({tag, ".done"}, 32'(done), 32'(dn));
        chk({tag, ".fill_count"}, 32'(fill_count), 32'(fc));
    endtask

    // Load 16 words (fixed pattern or random) with `gap` idle cycles between them.
    task automatic fill(input bit pat, input int gap);
        mdl.delete();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_op = pat ? 2'(i % 4) : 2'($urandom);
            in_a  = pat ? 8'(i) : 8'($urandom);
            in_b  = pat ? 8'(16 - i) : 8'($urandom);
            chk("fill.in_ready", 32'(in_ready), 32'd1);
            tick();
            mdl.push_back({in_op, in_a, in_b});
            chk("fill.fill_count", 32'(fill_count), 32'(mdl.size()));
            if (i < 15) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    in_a = 8'($urandom);
                    tick();
                    chk("stall.fill_count", 32'(fill_count), 32'(mdl.size()));
                end
            end
        end
        // Host keeps offering a word while full; it must be ignored.
        in_valid = 1'b1;
        in_a = 8'($urandom);
        expect_out("full", 1'b0, 1'b1, 18'd0, 1'b0, 1'b0, 5'd16);
    endtask

    task automatic run_prog(input bit hold, input bit rep);
        in_valid = hold;
        tick();
        expect_out("prime", 1'b0, 1'b1, mdl[0], 1'b1, 1'b0, 5'd16);
        for (int i = 0; i < 16; i++) begin
            in_valid = hold;
            in_op = 2'($urandom);
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            tick();
            expect_out("stream", 1'b0, 1'b0, mdl[i], 1'b1, 1'b0, 5'd16);
        end
        for (int r = 0; r < 18; r++) begin
`ifdef LOADER_REPEAT_EN
            repeat_prog = rep;
`endif
            tick();
            expect_out("run", 1'b0, 1'b0, 18'd0, 1'b1, r == 17, 5'd16);
        end
        in_valid = 1'b0;
`ifdef LOADER_REPEAT_EN
        repeat_prog = 1'b0;
`endif
        if (!rep) begin
            tick();
            expect_out("refill", 1'b1, 1'b1, 18'd0, 1'b0, 1'b0, 5'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        expect_out("reset", 1'b1, 1'b1, 18'd0, 1'b0, 1'b0, 5'd0);
        reset = 1'b0;

        fill(1'b1, 0);
        run_prog(1'b0, 1'b0);

        fill(1'b0, 3);
        run_prog(1'b1, 1'b0);

        fill(1'b0, 0);
        in_valid = 1'b0;
        tick();
        expect_out("abort.prime", 1'b0, 1'b1, mdl[0], 1'b1, 1'b0, 5'd16);
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_out("abort.stream", 1'b0, 1'b0, mdl[i], 1'b1, 1'b0, 5'd16);
        end
        reset = 1'b1;
        tick();
        expect_out("abort", 1'b1, 1'b1, 18'd0, 1'b0, 1'b0, 5'd0);
        reset = 1'b0;

        fill(1'b0, 1);
        run_prog(1'b1, 1'b0);

`ifdef LOADER_REPEAT_EN
        fill(1'b0, 0);
        run_prog(1'b1, 1'b1);
        run_prog(1'b1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/calc_program_loader.md
# calc_program_loader

Transmit-side companion to the 16-slot calculator. It accepts instruction words from a host over a valid/ready handshake and buffers a full program of DEPTH words. It then resets the calculator and streams the program onto the calculator's DIN on consecutive cycles. It sits between the host/test controller and the calculator, driving the calculator's reset and DIN and owning the calculator's program-load timing.

## Interface
- DEPTH, 16, words per program; must equal the calculator's instruction-memory depth
- RUN_CYCLES, 18, cycles held in RUN after streaming (calculator needs DEPTH+1 to execute, plus 1 margin)
- clk  input  1  single clock, shared with the calculator
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk
- in_valid  input  1  host word valid
- in_ready  output  1  loader can accept a word this cycle
- in_op  input  2  opcode, placed in DIN[17:16]
- in_a  input  8  operand A, placed in DIN[15:8]
- in_b  input  8  operand B, placed in DIN[7:0]
- calc_reset  output  1  drives the calculator reset
- calc_din  output  18  drives the calculator DIN
- busy  output  1  high in PRIME, STREAM and RUN
- done  output  1  one-cycle pulse on the last RUN cycle
- fill_count  output  5  words currently buffered, 0..DEPTH
- repeat_prog  input  1  present only with LOADER_REPEAT_EN

## Operation
- Buffer: DEPTH x 18-bit register array, written in order from index 0. Word layout is {in_op, in_a, in_b}.
- States: FILL, PRIME, STREAM, RUN.
- FILL:
  - in_ready = (fill_count < DEPTH).
  - A transfer happens when in_valid && in_ready; the word is written to buffer[fill_count] and fill_count increments.
  - Move to PRIME on the cycle after fill_count reaches DEPTH.
  - in_valid while in_ready is low is ignored; no overwrite occurs.
- PRIME: lasts 1 cycle. calc_reset = 1, calc_din = buffer[0]. Next state is STREAM, with stream index k = 0.
- STREAM: lasts DEPTH cycles. calc_reset = 0, calc_din = buffer[k], k increments each cycle. After k = DEPTH-1, go to RUN.
- RUN: lasts RUN_CYCLES cycles. calc_reset = 0, calc_din = 0. done pulses on the final cycle.
  - Without repeat: next state is FILL with fill_count cleared to 0.
  - With repeat (see Configuration): go to PRIME.
- calc_reset is 1 in FILL and PRIME, and 0 in STREAM and RUN. Consequence: the calculator's RESULT/NEG are cleared when a new fill begins, so consumers must sample during RUN.
- in_ready is 0 in every state except FILL.
- fill_count holds DEPTH through PRIME, STREAM and RUN.

## Timing
- Reset values:
  - State FILL, fill_count 0, k 0.
  - in_ready 1, calc_reset 1, calc_din 0, busy 0, done 0.
  - Buffer contents are not reset.
- All outputs are registered. A word accepted at edge N is reflected in fill_count after edge N.
- The calculator captures calc_din at each rising edge ending a STREAM cycle. Word k is therefore captured at the end of STREAM cycle k.
- Latency from the last accepted word to the first STREAM cycle is 2 cycles: the FILL→PRIME transition, then PRIME.
- Program period without repeat: fill time + 1 + DEPTH + RUN_CYCLES.
- Back-to-back host words are accepted every cycle. One word per cycle maximum.
- Reset asserted mid-STREAM or mid-RUN aborts the program. On the next cycle: FILL, fill_count 0, calc_reset 1, done 0.
- Simultaneous in_valid with the final FILL→PRIME transition: the word is not accepted, because in_ready is already low at fill_count = DEPTH.

## Configuration
- LOADER_REPEAT_EN
  - Defined: the repeat_prog port exists. If repeat_prog = 1 on the final RUN cycle, the next state is PRIME and the buffer is re-streamed unchanged, with fill_count kept at DEPTH.
  - Not defined: the port is absent and RUN always returns to FILL.

## Structure
- Shared calculator package:
  - OP width (2) and operand width (8)
  - DIN width (18)
  - DEPTH (16)
  - opcode constants
  - state enum {FILL, PRIME, STREAM, RUN}
  - a function packing op/a/b into an 18-bit word
- Single module. The buffer is inline; no sub-module is required.

## Test plan
- Reset, then 16 back-to-back words (op=i%4, a=i, b=16-i) → in_ready drops after 16 transfers. PRIME lasts 1 cycle with calc_reset=1 and calc_din=word0. calc_din then steps word0..word15 on 16 consecutive cycles with calc_reset=0.
- Host stalls with in_valid low for 3 cycles between every word → fill_count counts 0..16 correctly, with no duplicate or skipped buffer entries.
- in_valid held high during STREAM/RUN → in_ready stays 0, fill_count stays 16, buffer unchanged.
- Full program against a calculator instance, word (op=0, a=5, b=3) in every slot → done pulses exactly 1+16+18 cycles after PRIME. The calculator's RESULT is sampled during RUN.
- Reset asserted at STREAM k=7 → next cycle: FILL, fill_count 0, calc_reset 1, busy 0. A new 16-word fill then streams normally.
- With LOADER_REPEAT_EN and repeat_prog=1 → after done, PRIME follows immediately and the identical 16 words re-stream. With repeat_prog=0 → FILL with fill_count 0.
